seq_gen_010: RTL and testbench

- Serial stimulus transmitter that emits a programmable burst of "010" frames on a single-bit line.
- Consecutive frames are separated by a programmable run of 1s.
- Drives the x input of the 010 sequence detector. The detector's users_count must then advance by exactly the number of frames sent.
- Reports progress (busy, done, sent_count) to the controlling bench or sequencer.

---
 rtl/seq_gen_010.sv | 108 ++++++++++
 tb/tb_seq_gen_010.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen_010.sv
// Serial "010" frame burst generator driving the x input of a 010 sequence detector.
// Frames are separated by a programmable run of idle 1s; the line idles high.
module seq_gen_010 #(
    parameter int CNT_W = 10,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] burst_count,
    input  logic [GAP_W-1:0] gap_len,
    output logic             x_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_count
);

    // state | meaning
    // IDLE  | line high, waiting for start
    // B0    | first bit of frame, line low
    // B1    | middle bit of frame, line high
    // B2    | last bit of frame, line low; frame counted on entry
    // GAP   | idle 1s between frames, gap counter running down
    typedef enum logic [2:0] {IDLE, B0, B1, B2, GAP} state_t;

    state_t           state;
    logic [CNT_W-1:0] rem;
    logic [GAP_W-1:0] gap_ld;
    logic [GAP_W-1:0] gap_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            x_out      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            sent_count <= '0;
            rem        <= '0;
            gap_ld     <= '0;
            gap_cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                x_out <= 1'b1;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            rem        <= burst_count;
                            gap_ld     <= gap_len;
                            sent_count <= '0;
                            if (burst_count == '0) begin
                                done <= 1'b1;
                            end else begin
                                state <= B0;
                                x_out <= 1'b0;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    B0: begin
                        state <= B1;
                        x_out <= 1'b1;
                    end
                    B1: begin
                        state      <= B2;
                        x_out      <= 1'b0;
                        sent_count <= sent_count + CNT_W'(1);
                        rem        <= rem - CNT_W'(1);
                    end
                    B2: begin
                        // rem already reflects the frame just completed
                        if (rem == '0) begin
                            state <= IDLE;
                            x_out <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (gap_ld == '0) begin
                            state <= B0;
                            x_out <= 1'b0;
                        end else begin
                            state   <= GAP;
                            x_out   <= 1'b1;
                            gap_cnt <= gap_ld;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_W'(1)) begin
                            state <= B0;
                            x_out <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        x_out <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_gen_010.sv
// Bench for seq_gen_010: stream-level queue model checked every cycle, plus
// hand-computed literal expectations and a simple 010 detector on x_out.
module tb_seq_gen_010;
    localparam int CNT_W = 10;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] burst_count = '0;
    logic [GAP_W-1:0] gap_len = '0;
    logic             x_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent_count;

    int n_checks = 0;
    int n_fail   = 0;
    int users_count = 0;
    logic [2:0] det_sh = 3'b111;

    seq_gen_010 #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .burst_count(burst_count), .gap_len(gap_len),
        .x_out(x_out), .busy(busy), .done(done), .sent_count(sent_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             x;
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] sent;
    } exp_t;

    exp_t cur = '{x: 1'b1, busy: 1'b0, done: 1'b0, sent: '0};
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Model: an accepted start expands the whole burst into a queue of
    // per-cycle expected outputs; abort discards what is left.
    always @(posedge clk or posedge rst) begin
        exp_t nxt;
        if (rst) begin
            q.delete();
            cur <= '{x: 1'b1, busy: 1'b0, done: 1'b0, sent: '0};
        end else begin
            nxt = '{x: 1'b1, busy: 1'b0, done: 1'b0, sent: cur.sent};
            if (cur.busy && abort) begin
                q.delete();
            end else if (!cur.busy && start && !abort) begin
                q.delete();
                for (int f = 1; f <= int'(burst_count); f++) begin
                    q.push_back('{x: 1'b0, busy: 1'b1, done: 1'b0, sent: CNT_W'(f - 1)});
                    q.push_back('{x: 1'b1, busy: 1'b1, done: 1'b0, sent: CNT_W'(f - 1)});
                    q.push_back('{x: 1'b0, busy: 1'b1, done: 1'b0, sent: CNT_W'(f)});
                    if (f < int'(burst_count))
                        for (int g = 0; g < int'(gap_len); g++)
                            q.push_back('{x: 1'b1, busy: 1'b1, done: 1'b0, sent: CNT_W'(f)});
                end
                q.push_back('{x: 1'b1, busy: 1'b0, done: 1'b1, sent: burst_count});
                nxt = q.pop_front();
            end else if (q.size() > 0) begin
                nxt = q.pop_front();
            end
            cur <= nxt;
        end
    end

    always @(negedge clk) begin
        det_sh = {det_sh[1:0], x_out};
        if (det_sh == 3'b010) users_count++;
        check("model x_out", x_out, cur.x);
        check("model busy", busy, cur.busy);
        check("model done", done, cur.done);
        check("model sent_count", sent_count, cur.sent);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int bc, input int gl);
        burst_count = CNT_W'(bc);
        gap_len     = GAP_W'(gl);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    initial begin
        logic [7:0] pat2;
        logic [8:0] pat3;
        int u0;
        pat2 = 8'b01011010;
        pat3 = 9'b010010010;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle x_out", x_out, 1);
            check("idle busy", busy, 0);
            check("idle done", done, 0);
            check("idle sent_count", sent_count, 0);
        end

        // two frames, gap 2
        u0 = users_count;
        start_burst(2, 2);
        for (int i = 0; i < 8; i++) begin
            check("b2g2 x_out", x_out, pat2[7-i]);
            check("b2g2 busy", busy, 1);
            tick();
        end
        check("b2g2 done", done, 1);
        check("b2g2 busy end", busy, 0);
        check("b2g2 sent_count", sent_count, 2);
        tick();
        check("b2g2 done width", done, 0);
        check("b2g2 detector", users_count - u0, 2);

        // three frames back to back
        u0 = users_count;
        start_burst(3, 0);
        for (int i = 0; i < 9; i++) begin
            check("b3g0 x_out", x_out, pat3[8-i]);
            check("b3g0 busy", busy, 1);
            tick();
        end
        check("b3g0 done", done, 1);
        check("b3g0 sent_count", sent_count, 3);
        tick();
        check("b3g0 detector", users_count - u0, 3);

        // zero-length burst
        start_burst(0, 5);
        check("b0 done", done, 1);
        check("b0 busy", busy, 0);
        check("b0 x_out", x_out, 1);
        check("b0 sent_count", sent_count, 0);
        tick();
        check("b0 done width", done, 0);

        // abort after second frame, ignored mid-burst start
        start_burst(5, 1);
        tick();
        tick();
        burst_count = CNT_W'(1);
        gap_len     = GAP_W'(0);
        start       = 1'b1;
        tick();
        start       = 1'b0;
        for (int i = 3; i < 7; i++) tick();
        check("abort pre x_out", x_out, 1);
        check("abort pre sent_count", sent_count, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort x_out", x_out, 1);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort sent_count", sent_count, 2);
        tick();
        check("abort no done", done, 0);

        // abort and start together in IDLE
        burst_count = CNT_W'(2);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort+start busy", busy, 0);
        check("abort+start sent_count", sent_count, 2);

        // async reset during B1 of the first frame
        start_burst(4, 0);
        tick();
        check("pre-rst x_out", x_out, 1);
        check("pre-rst busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rst x_out", x_out, 1);
        check("rst busy", busy, 0);
        check("rst sent_count", sent_count, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        tick();
        u0 = users_count;
        start_burst(1, 3);
        check("post-rst b0", x_out, 0);
        tick();
        check("post-rst b1", x_out, 1);
        tick();
        check("post-rst b2", x_out, 0);
        tick();
        check("post-rst done", done, 1);
        check("post-rst sent_count", sent_count, 1);
        check("post-rst x_out idle", x_out, 1);
        tick();
        check("post-rst detector", users_count - u0, 1);

        // maximum gap
        start_burst(2, 15);
        for (int i = 0; i < 3 + 15 + 3; i++) tick();
        check("gap15 done", done, 1);
        check("gap15 sent_count", sent_count, 2);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
